// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer for the out-of-order core.
// Allocates ROB tags at issue, captures results from the CDB and retires
// entries strictly in program order through a registered commit port.
// Optional build macro: ROB_CDB_BYPASS_EN -- when defined, operand lookups
// also see a same-cycle CDB broadcast to a valid entry.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush,
  input  logic              issue_en,
  input  logic              issue_has_rd,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              full,
  output logic              empty,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_en,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_dest,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] commit_data
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  // Per-entry state
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  has_rd_q;
  logic [REG_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;

  logic do_alloc;
  logic do_commit;
  logic do_wb;

  // Issue handshake: an allocation happens on a rising edge where
  // issue_en && issue_ready; issue_ready depends only on start-of-cycle
  // occupancy and stall_i, never on issue_en. A request seen while
  // issue_ready is low is dropped, so upstream must hold it until accepted.
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign issue_ready = !full && !stall_i;
  assign alloc_tag   = tail_q;

  assign do_alloc  = issue_en && issue_ready;
  assign do_commit = valid_q[head_q] && done_q[head_q];
  assign do_wb     = cdb_valid && valid_q[cdb_tag];

  // Control state, pointers, occupancy and registered commit port
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= '0;
      done_q      <= '0;
      has_rd_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      commit_en   <= 1'b0;
      commit_we   <= 1'b0;
      commit_dest <= '0;
      commit_tag  <= '0;
      commit_data <= '0;
    end else begin
      if (do_wb) begin
        done_q[cdb_tag] <= 1'b1;
      end
      commit_en <= do_commit;
      if (do_commit) begin
        commit_tag      <= head_q;
        commit_dest     <= dest_q[head_q];
        commit_data     <= data_q[head_q];
        commit_we       <= has_rd_q[head_q] && (dest_q[head_q] != '0);
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // Allocation comes last so it wins over a writeback to the same slot.
      if (do_alloc) begin
        valid_q[tail_q]  <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        has_rd_q[tail_q] <= issue_has_rd;
        tail_q           <= tail_q + 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage: destination captured at issue, result at writeback
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (do_wb) begin
        data_q[cdb_tag] <= cdb_data;
      end
      if (do_alloc) begin
        dest_q[tail_q] <= issue_rd;
      end
    end
  end

  // Operand lookup port 1: ready only for a valid, completed entry
  always_comb begin
    q1_ready = valid_q[q1_tag] && done_q[q1_tag];
    q1_data  = q1_ready ? data_q[q1_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == q1_tag) && valid_q[q1_tag]) begin
      q1_ready = 1'b1;
      q1_data  = cdb_data;
    end
`endif
  end

  // Operand lookup port 2: same behaviour as port 1
  always_comb begin
    q2_ready = valid_q[q2_tag] && done_q[q2_tag];
    q2_data  = q2_ready ? data_q[q2_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == q2_tag) && valid_q[q2_tag]) begin
      q2_ready = 1'b1;
      q2_data  = cdb_data;
    end
`endif
  end

endmodule
